// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults, event record and width helper for the debounce scheduler
package debounce_pkg;

    localparam int DEF_N_INPUTS = 4;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_EVT_DEPTH = 4;
    localparam int ID_W_MAX = 4;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic                level;
    } event_t;

    function automatic int width_of(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_event_fifo.sv
// debounce_event_fifo: first-word-fall-through event queue with extra-bit pointers
module debounce_event_fifo
    import debounce_pkg::*;
#(
    parameter int DEPTH = DEF_EVT_DEPTH
)(
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  event_t push_data,
    input  logic   pop,
    output event_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = width_of(DEPTH);

    event_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign empty = wr_ptr == rd_ptr;
    assign full = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push && !rst)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: round-robin debouncer sharing one compare/count datapath across channels
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int EVT_DEPTH = DEF_EVT_DEPTH
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_INPUTS-1:0]         noisy_in,
    input  logic                        scan_en,
    output logic [N_INPUTS-1:0]         clean_out,
    output logic                        event_valid,
    input  logic                        event_ready,
    output logic [$clog2(N_INPUTS)-1:0] event_id,
    output logic                        event_level
);

    localparam int IW = $clog2(N_INPUTS);
    localparam int CW = width_of(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
    localparam logic [IW-1:0] PLAST = IW'(N_INPUTS - 1);

    logic [N_INPUTS-1:0] sync1, sync2, prev;
    logic [CW-1:0] cnt [N_INPUTS];
    logic [IW-1:0] ptr;
    logic [CW-1:0] c;
    logic s, same, commit, full, empty;
    event_t push_data, head;
    logic [ID_W_MAX-1:0] head_id_unused;

    assign s = sync2[ptr];
    assign c = cnt[ptr];
    assign same = s == prev[ptr];
    // a full queue holds the commit back with cnt saturated, so the next visit retries it
    assign commit = scan_en && same && c == CMAX && s != clean_out[ptr] && !full;
    assign push_data = '{id: ID_W_MAX'(ptr), level: s};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev <= '0;
            clean_out <= '0;
            ptr <= '0;
            for (int i = 0; i < N_INPUTS; i++)
                cnt[i] <= '0;
        end else begin
            sync1 <= noisy_in;
            sync2 <= sync1;
            if (scan_en) begin
                ptr <= ptr == PLAST ? '0 : ptr + IW'(1);
                if (!same) begin
                    prev[ptr] <= s;
                    cnt[ptr] <= '0;
                end else if (c < CMAX) begin
                    cnt[ptr] <= c + CW'(1);
                end
                if (commit)
                    clean_out[ptr] <= s;
            end
        end
    end

    debounce_event_fifo #(.DEPTH(EVT_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (commit),
        .push_data (push_data),
        .pop       (event_valid && event_ready),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign head_id_unused = head.id;
    assign event_valid = !empty;
    assign event_id = head_id_unused[IW-1:0];
    assign event_level = head.level;

endmodule
